// File: rtl/adder_cla4.sv
`default_nettype none
// ============================================================================
//  Module   : adder_cla4
//  Purpose  : 4-bit carry-lookahead slice. Produces the 4-bit sum for its
//             nibble plus the group generate/propagate terms consumed by the
//             second-level lookahead unit in the parent adder.
//  Ports    : i_a, i_b  - 4-bit addend nibbles
//             i_cin     - carry into bit 0 of this nibble
//             o_sum     - 4-bit sum
//             o_g       - group generate (nibble creates a carry by itself)
//             o_p       - group propagate (nibble passes i_cin through)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_g,
    output logic       o_p
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Fully expanded lookahead: every internal carry depends only on the
    // bit-level g/p terms and i_cin, never on a neighbouring carry.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ w_c;

    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p = &w_p;

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module   : adder
//  Purpose  : 32-bit carry-lookahead adder with carry-in/carry-out and a
//             signed-overflow flag. Sum, carry and overflow are combinational
//             (zero latency); a registered copy of all three is provided for
//             pipelined consumers (one cycle latency, synchronous reset).
//  Ports    : clk       - system clock, rising edge
//             reset     - synchronous active-high reset (registered outputs)
//             operand1  - addend A (unsigned or two's complement)
//             operand2  - addend B
//             cin       - carry into bit 0
//             result    - combinational operand1 + operand2 + cin (mod 2^32)
//             cout      - combinational carry out of bit 31
//             overflow  - combinational signed overflow
//             result_q  - registered result
//             cout_q    - registered cout
//             ovf_q     - registered overflow
//  Revision : 1.0 - initial release
// ============================================================================
module adder #(
    localparam int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic [WIDTH-1:0] result_q,
    output logic             cout_q,
    output logic             ovf_q
);

    localparam int GROUPS = WIDTH / 4;
    localparam int BLOCKS = GROUPS / 4;

    logic [GROUPS-1:0] w_gg;       // per-nibble group generate
    logic [GROUPS-1:0] w_gp;       // per-nibble group propagate
    logic [GROUPS:0]   w_c;        // carry into each nibble; w_c[GROUPS] = cout
    logic [WIDTH-1:0]  w_sum;

    logic [WIDTH-1:0]  r_result;
    logic              r_cout;
    logic              r_ovf;

    // ------------------------------------------------------------------
    // First level: eight 4-bit lookahead slices.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
            adder_cla4 u_cla4 (
                .i_a   (operand1[4*gi +: 4]),
                .i_b   (operand2[4*gi +: 4]),
                .i_cin (w_c[gi]),
                .o_sum (w_sum[4*gi +: 4]),
                .o_g   (w_gg[gi]),
                .o_p   (w_gp[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Second level: group carries c4..c32. Nibbles are handled in blocks
    // of four; inside a block every group carry is a flat expansion of the
    // group g/p terms and the block carry-in, so only the carry from one
    // 16-bit block to the next is chained.
    // ------------------------------------------------------------------
    assign w_c[0] = cin;

    generate
        for (genvar bi = 0; bi < BLOCKS; bi++) begin : g_blk
            localparam int B = 4 * bi;
            assign w_c[B+1] = w_gg[B] | (w_gp[B] & w_c[B]);
            assign w_c[B+2] = w_gg[B+1] | (w_gp[B+1] & w_gg[B])
                            | (w_gp[B+1] & w_gp[B] & w_c[B]);
            assign w_c[B+3] = w_gg[B+2] | (w_gp[B+2] & w_gg[B+1])
                            | (w_gp[B+2] & w_gp[B+1] & w_gg[B])
                            | (w_gp[B+2] & w_gp[B+1] & w_gp[B] & w_c[B]);
            assign w_c[B+4] = w_gg[B+3] | (w_gp[B+3] & w_gg[B+2])
                            | (w_gp[B+3] & w_gp[B+2] & w_gg[B+1])
                            | (w_gp[B+3] & w_gp[B+2] & w_gp[B+1] & w_gg[B])
                            | (w_gp[B+3] & w_gp[B+2] & w_gp[B+1] & w_gp[B] & w_c[B]);
        end
    endgenerate

    assign result = w_sum;
    assign cout   = w_c[GROUPS];

    // Signed overflow: operands share a sign and the sum's sign differs.
    assign overflow = (operand1[WIDTH-1] == operand2[WIDTH-1])
                   && (w_sum[WIDTH-1] != operand1[WIDTH-1]);

    // ------------------------------------------------------------------
    // Registered copy for pipelined consumers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_sum;
            r_cout   <= w_c[GROUPS];
            r_ovf    <= overflow;
        end
    end

    assign result_q = r_result;
    assign cout_q   = r_cout;
    assign ovf_q    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder
//  Purpose  : Self-checking bench for adder. Directed vectors with
//             hand-computed results, a registered-path/reset sequence, and a
//             block of random vectors checked against a 33-bit reference sum.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder;

    logic        clk;
    logic        reset;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        cin;
    logic [31:0] result;
    logic        cout;
    logic        overflow;
    logic [31:0] result_q;
    logic        cout_q;
    logic        ovf_q;

    int n_tests;
    int n_fail;

    adder dut (
        .clk      (clk),
        .reset    (reset),
        .operand1 (operand1),
        .operand2 (operand2),
        .cin      (cin),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .result_q (result_q),
        .cout_q   (cout_q),
        .ovf_q    (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a vector, let it settle, then check the combinational outputs.
    task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic [31:0] e_res, input logic e_cout,
                            input logic e_ovf);
        operand1 = a;
        operand2 = b;
        cin      = c;
        #1;
        check({tag, ".result"},   64'(result),   64'(e_res));
        check({tag, ".cout"},     64'(cout),     64'(e_cout));
        check({tag, ".overflow"}, 64'(overflow), 64'(e_ovf));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref_sum;
        logic        ref_ovf;

        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        operand1 = 32'h0;
        operand2 = 32'h0;
        cin      = 1'b0;

        // Reset state of the registered outputs.
        @(posedge clk);
        #1;
        check("rst.result_q", 64'(result_q), 64'h0);
        check("rst.cout_q",   64'(cout_q),   64'h0);
        check("rst.ovf_q",    64'(ovf_q),    64'h0);
        reset = 1'b0;

        // Directed combinational vectors.
        comb_vec("zero",      32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        comb_vec("ff+1",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        comb_vec("ff+1+c",    32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        comb_vec("ff+0+c",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        comb_vec("ff+ff+c",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        comb_vec("7f+1",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        comb_vec("80+80",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        comb_vec("mixed",     32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        comb_vec("nib_chain", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        comb_vec("neg+pos",   32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1'b0);

        // Registered path: one edge of latency.
        operand1 = 32'h1234_5678;
        operand2 = 32'h1111_1111;
        cin      = 1'b1;
        @(posedge clk);
        #1;
        check("reg.result_q", 64'(result_q), 64'h2345_678A);
        check("reg.cout_q",   64'(cout_q),   64'h0);
        check("reg.ovf_q",    64'(ovf_q),    64'h0);

        operand1 = 32'hFFFF_FFFF;
        operand2 = 32'h0000_0001;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        check("reg2.result_q", 64'(result_q), 64'h0);
        check("reg2.cout_q",   64'(cout_q),   64'h1);

        // Mid-stream reset clears only the registered copy.
        operand1 = 32'h7FFF_FFFF;
        operand2 = 32'h0000_0001;
        cin      = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("mrst.result_q", 64'(result_q), 64'h0);
        check("mrst.cout_q",   64'(cout_q),   64'h0);
        check("mrst.ovf_q",    64'(ovf_q),    64'h0);
        check("mrst.result",   64'(result),   64'h8000_0000);
        check("mrst.overflow", 64'(overflow), 64'h1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post.result_q", 64'(result_q), 64'h8000_0000);
        check("post.ovf_q",    64'(ovf_q),    64'h1);

        // Random vectors against a 33-bit reference sum.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            operand1 = ra;
            operand2 = rb;
            cin      = rc;
            #10;
            ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            ref_ovf = (ra[31] == rb[31]) && (ref_sum[31] != ra[31]);
            check("rand.sum", 64'({cout, result}), 64'(ref_sum));
            check("rand.ovf", 64'(overflow),       64'(ref_ovf));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
